memory_arbiter: RTL and testbench

Two-port-to-one arbiter sharing a single unified memory between the instruction-fetch stage and the data-memory (MEM) stage of the RV32IM pipeline. It is a three-state FSM that accepts busywait-style requests from both stages and registers the winning address, data and command toward memory. It stalls the loser via its busywait and applies data-first priority with a starvation guard for fetch. It sits between the PC/IF logic and the data-memory stage on one side and the single memory model on the other.

---
 rtl/memory_arbiter_if.sv | 30 +++
 rtl/memory_arbiter.sv | 61 ++++++
 tb/tb_memory_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: fetch, data and unified-memory buses around the memory arbiter.
interface memory_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  if_read;
   logic [ADDR_WIDTH-1:0] if_address;
   logic [DATA_WIDTH-1:0] if_readdata;
   logic                  if_busywait;
   logic                  dm_read;
   logic                  dm_write;
   logic [ADDR_WIDTH-1:0] dm_address;
   logic [DATA_WIDTH-1:0] dm_writedata;
   logic [DATA_WIDTH-1:0] dm_readdata;
   logic                  dm_busywait;
   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_writedata;
   logic [DATA_WIDTH-1:0] mem_readdata;
   logic                  mem_busywait;
   modport master (
      output if_read, if_address, dm_read, dm_write, dm_address, dm_writedata, mem_readdata, mem_busywait,
      input  if_readdata, if_busywait, dm_readdata, dm_busywait, mem_read, mem_write, mem_address, mem_writedata
   );
   modport slave (
      input  if_read, if_address, dm_read, dm_write, dm_address, dm_writedata, mem_readdata, mem_busywait,
      output if_readdata, if_busywait, dm_readdata, dm_busywait, mem_read, mem_write, mem_address, mem_writedata
   );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory between fetch and data ports, data-first with a fetch starvation guard.
module memory_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic             clk,
   input logic             reset,
   memory_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_DM} state_t;
   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] starve_cnt;
   logic          dm_both;
   logic          dm_req;
   logic          grant_if;
   logic          grant_dm;
   logic          done;
   always_comb begin
      dm_req   = bus.dm_read | bus.dm_write;
      grant_if = bus.if_read && (!dm_req || starve_cnt == CW'(STARVE_LIMIT));
      grant_dm = dm_req && !grant_if;
      done     = state != IDLE && !bus.mem_busywait;
   end
   always_comb
      state_nxt = state == IDLE ? (grant_if ? SERVE_IF : (grant_dm ? SERVE_DM : IDLE)) : (done ? IDLE : state);
   always_ff @(posedge clk)
      if (reset) begin
         state             <= IDLE;
         starve_cnt        <= '0;
         dm_both           <= 1'b0;
         bus.mem_read      <= 1'b0;
         bus.mem_write     <= 1'b0;
         bus.mem_address   <= '0;
         bus.mem_writedata <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            starve_cnt <= (grant_if || !bus.if_read) ? '0 :
                          (grant_dm && starve_cnt != CW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
            if (grant_if || grant_dm) begin
               bus.mem_address <= grant_if ? bus.if_address : bus.dm_address;
               bus.mem_read    <= grant_if || !bus.dm_write;
               bus.mem_write   <= grant_dm && bus.dm_write;
               dm_both         <= grant_dm && bus.dm_read && bus.dm_write;
            end
            if (grant_dm)
               bus.mem_writedata <= bus.dm_writedata;
         end else if (done) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
         end
      end
   // A read-and-write request is served as a write, so it must not leak memory data back as load data.
   always_comb begin
      bus.if_busywait = bus.if_read && !(!reset && state == SERVE_IF && !bus.mem_busywait);
      bus.dm_busywait = dm_req && !(!reset && state == SERVE_DM && !bus.mem_busywait);
      bus.if_readdata = (!reset && state == SERVE_IF) ? bus.mem_readdata : '0;
      bus.dm_readdata = (!reset && state == SERVE_DM && !dm_both) ? bus.mem_readdata : '0;
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model.
module tb_memory_arbiter;
   localparam int LIMIT = 4;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic drop_all();
      bus.if_read  = 1'b0;
      bus.dm_read  = 1'b0;
      bus.dm_write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drop_all();
      bus.if_read = 1'b1;
      bus.if_address = 32'h44;
      bus.dm_address = 32'h0;
      bus.dm_writedata = 32'h0;
      bus.mem_busywait = 1'b1;
      bus.mem_readdata = 32'h1234_5678;
      repeat (2) @(negedge clk);
      #1;
      n_vec++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read: got %b expected 0", bus.mem_read); end
      n_vec++; if (bus.mem_address !== 32'h0) begin n_bad++; $display("FAIL reset_mem_address: got %h expected 0", bus.mem_address); end
      n_vec++; if (bus.if_busywait !== 1'b1) begin n_bad++; $display("FAIL reset_if_busywait: got %b expected 1", bus.if_busywait); end
      n_vec++; if (bus.if_readdata !== 32'h0) begin n_bad++; $display("FAIL reset_if_readdata: got %h expected 0", bus.if_readdata); end
      reset = 1'b0;
      @(negedge clk);
      #1;
      n_vec++; if (bus.mem_read !== 1'b1) begin n_bad++; $display("FAIL post_reset_mem_read: got %b expected 1", bus.mem_read); end
      n_vec++; if (bus.mem_address !== 32'h44) begin n_bad++; $display("FAIL post_reset_mem_address: got %h expected 44", bus.mem_address); end
      bus.mem_busywait = 1'b0;
      #1;
      n_vec++; if (bus.if_busywait !== 1'b0) begin n_bad++; $display("FAIL post_reset_if_busywait: got %b expected 0", bus.if_busywait); end
      n_vec++; if (bus.if_readdata !== 32'h1234_5678) begin n_bad++; $display("FAIL post_reset_if_readdata: got %h expected 12345678", bus.if_readdata); end
      @(negedge clk);
      drop_all();
      #1;
      n_vec++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got %b expected 0", bus.mem_read); end
   endtask

   task automatic test_lone_fetch();
      @(negedge clk);
      bus.if_read = 1'b1;
      bus.if_address = 32'h10;
      bus.mem_busywait = 1'b0;
      bus.mem_readdata = 32'h0050_0093;
      #1;
      n_vec++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL fetch_c1_mem_read: got %b expected 0", bus.mem_read); end
      n_vec++; if (bus.if_busywait !== 1'b1) begin n_bad++; $display("FAIL fetch_c1_busywait: got %b expected 1", bus.if_busywait); end
      @(negedge clk);
      #1;
      n_vec++; if (bus.mem_read !== 1'b1) begin n_bad++; $display("FAIL fetch_c2_mem_read: got %b expected 1", bus.mem_read); end
      n_vec++; if (bus.mem_address !== 32'h10) begin n_bad++; $display("FAIL fetch_c2_mem_address: got %h expected 10", bus.mem_address); end
      n_vec++; if (bus.if_busywait !== 1'b0) begin n_bad++; $display("FAIL fetch_c2_busywait: got %b expected 0", bus.if_busywait); end
      n_vec++; if (bus.if_readdata !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_c2_readdata: got %h expected 00500093", bus.if_readdata); end
      @(negedge clk);
      drop_all();
      #1;
      n_vec++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL fetch_c3_mem_read: got %b expected 0", bus.mem_read); end
      n_vec++; if (bus.if_readdata !== 32'h0) begin n_bad++; $display("FAIL fetch_c3_readdata: got %h expected 0", bus.if_readdata); end
   endtask

   task automatic test_dm_store_wait();
      @(negedge clk);
      bus.dm_write = 1'b1;
      bus.dm_address = 32'h100;
      bus.dm_writedata = 32'hDEAD_BEEF;
      bus.mem_busywait = 1'b1;
      #1;
      n_vec++; if (bus.dm_busywait !== 1'b1) begin n_bad++; $display("FAIL store_idle_busywait: got %b expected 1", bus.dm_busywait); end
      n_vec++; if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL store_idle_mem_write: got %b expected 0", bus.mem_write); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mem_busywait = (i < 3);
         #1;
         n_vec++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL store_cmd[%0d]: got wr=%b rd=%b expected wr=1 rd=0", i, bus.mem_write, bus.mem_read); end
         n_vec++; if (bus.mem_address !== 32'h100 || bus.mem_writedata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL store_hold[%0d]: got %h/%h expected 100/deadbeef", i, bus.mem_address, bus.mem_writedata); end
         n_vec++; if (bus.dm_busywait !== 1'(i < 3)) begin n_bad++; $display("FAIL store_busywait[%0d]: got %b expected %b", i, bus.dm_busywait, i < 3); end
      end
      @(negedge clk);
      drop_all();
      bus.mem_busywait = 1'b0;
      #1;
      n_vec++; if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL store_idle_after: got %b expected 0", bus.mem_write); end
   endtask

   task automatic test_starvation();
      int got[$];
      int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
      logic prev = 1'b0;
      @(negedge clk);
      bus.if_read = 1'b1;
      bus.if_address = 32'h200;
      bus.dm_read = 1'b1;
      bus.dm_address = 32'h300;
      bus.mem_busywait = 1'b0;
      for (int c = 0; c < 60 && got.size() < 10; c++) begin
         #1;
         if ((bus.mem_read | bus.mem_write) && !prev)
            got.push_back(bus.mem_address == 32'h200 ? 1 : 2);
         prev = bus.mem_read | bus.mem_write;
         @(negedge clk);
      end
      drop_all();
      n_vec++; if (got.size() != 10) begin n_bad++; $display("FAIL starve_grant_count: got %0d expected 10", got.size()); end
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         n_vec++; if (got[i] != exp_order[i]) begin n_bad++; $display("FAIL starve_grant[%0d]: got port %0d expected port %0d", i, got[i], exp_order[i]); end
      end
   endtask

   task automatic test_both_high();
      @(negedge clk);
      bus.dm_read = 1'b1;
      bus.dm_write = 1'b1;
      bus.dm_address = 32'h40;
      bus.dm_writedata = 32'h0000_A5A5;
      bus.mem_busywait = 1'b0;
      bus.mem_readdata = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      n_vec++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL both_cmd: got wr=%b rd=%b expected wr=1 rd=0", bus.mem_write, bus.mem_read); end
      n_vec++; if (bus.dm_readdata !== 32'h0) begin n_bad++; $display("FAIL both_readdata: got %h expected 0", bus.dm_readdata); end
      n_vec++; if (bus.dm_busywait !== 1'b0) begin n_bad++; $display("FAIL both_busywait: got %b expected 0", bus.dm_busywait); end
      n_vec++; if (bus.mem_writedata !== 32'h0000_A5A5) begin n_bad++; $display("FAIL both_writedata: got %h expected 0000a5a5", bus.mem_writedata); end
      @(negedge clk);
      drop_all();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.dm_write = 1'b1;
      bus.dm_address = 32'h80;
      bus.dm_writedata = 32'h77;
      bus.mem_busywait = 1'b1;
      @(negedge clk);
      #1;
      n_vec++; if (bus.mem_write !== 1'b1) begin n_bad++; $display("FAIL rmid_serving: got %b expected 1", bus.mem_write); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_vec++; if (bus.dm_busywait !== 1'b1 || bus.dm_readdata !== 32'h0) begin n_bad++; $display("FAIL rmid_during: got bw=%b rd=%h expected bw=1 rd=0", bus.dm_busywait, bus.dm_readdata); end
      n_vec++; if (bus.if_busywait !== 1'b0) begin n_bad++; $display("FAIL rmid_if_busywait: got %b expected 0", bus.if_busywait); end
      @(negedge clk);
      reset = 1'b0;
      drop_all();
      #1;
      n_vec++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL rmid_after_cmd: got wr=%b rd=%b expected 0/0", bus.mem_write, bus.mem_read); end
      bus.if_read = 1'b1;
      bus.if_address = 32'h88;
      @(negedge clk);
      bus.mem_busywait = 1'b0;
      #1;
      n_vec++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h88) begin n_bad++; $display("FAIL rmid_idle_grant: got rd=%b addr=%h expected 1/88", bus.mem_read, bus.mem_address); end
      @(negedge clk);
      drop_all();
   endtask

   // Model tracks one in-flight access as a record; grants follow the data-first/starvation rule.
   task automatic test_random();
      bit act, wr, both, if_p, dm_p, cpl, done_if, done_dm;
      int port, waits, starve, k;
      logic [31:0] m_addr, m_wdata, e_ifd, e_dmd;
      logic e_ifb, e_dmb;
      act = 0; wr = 0; both = 0; if_p = 0; dm_p = 0; port = 0; waits = 0; starve = 0;
      m_addr = '0; m_wdata = '0;
      @(negedge clk);
      reset = 1'b1;
      drop_all();
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!if_p && $urandom_range(2) != 0) begin
            if_p = 1;
            bus.if_address = $urandom;
         end
         bus.if_read = if_p;
         if (!dm_p && $urandom_range(2) != 0) begin
            dm_p = 1;
            k = int'($urandom_range(3));
            bus.dm_read = (k != 1);
            bus.dm_write = (k == 1 || k == 2);
            bus.dm_address = $urandom;
            bus.dm_writedata = $urandom;
         end
         if (!dm_p) begin
            bus.dm_read = 1'b0;
            bus.dm_write = 1'b0;
         end
         bus.mem_busywait = act ? (waits > 0) : 1'($urandom_range(1));
         bus.mem_readdata = $urandom;
         #1;
         cpl = act && !bus.mem_busywait;
         e_ifb = if_p && !(cpl && port == 1);
         e_dmb = dm_p && !(cpl && port == 2);
         e_ifd = (act && port == 1) ? bus.mem_readdata : 32'h0;
         e_dmd = (act && port == 2 && !both) ? bus.mem_readdata : 32'h0;
         n_vec++; if (bus.mem_read !== (act && !wr)) begin n_bad++; $display("FAIL rand_mem_read @%0d: got %b expected %b", c, bus.mem_read, act && !wr); end
         n_vec++; if (bus.mem_write !== (act && wr)) begin n_bad++; $display("FAIL rand_mem_write @%0d: got %b expected %b", c, bus.mem_write, act && wr); end
         n_vec++; if (bus.mem_address !== m_addr) begin n_bad++; $display("FAIL rand_mem_address @%0d: got %h expected %h", c, bus.mem_address, m_addr); end
         n_vec++; if (bus.mem_writedata !== m_wdata) begin n_bad++; $display("FAIL rand_mem_writedata @%0d: got %h expected %h", c, bus.mem_writedata, m_wdata); end
         n_vec++; if (bus.if_busywait !== e_ifb) begin n_bad++; $display("FAIL rand_if_busywait @%0d: got %b expected %b", c, bus.if_busywait, e_ifb); end
         n_vec++; if (bus.dm_busywait !== e_dmb) begin n_bad++; $display("FAIL rand_dm_busywait @%0d: got %b expected %b", c, bus.dm_busywait, e_dmb); end
         n_vec++; if (bus.if_readdata !== e_ifd) begin n_bad++; $display("FAIL rand_if_readdata @%0d: got %h expected %h", c, bus.if_readdata, e_ifd); end
         n_vec++; if (bus.dm_readdata !== e_dmd) begin n_bad++; $display("FAIL rand_dm_readdata @%0d: got %h expected %h", c, bus.dm_readdata, e_dmd); end
         done_if = if_p && cpl && port == 1;
         done_dm = dm_p && cpl && port == 2;
         if (act) begin
            if (cpl) act = 0;
            else waits--;
         end else begin
            if (!if_p) starve = 0;
            if (if_p || dm_p) begin
               port = (if_p && (!dm_p || starve == LIMIT)) ? 1 : 2;
               starve = port == 1 ? 0 : (if_p && starve < LIMIT) ? starve + 1 : starve;
               act = 1;
               waits = int'($urandom_range(3));
               m_addr = port == 1 ? bus.if_address : bus.dm_address;
               if (port == 2) m_wdata = bus.dm_writedata;
               wr = port == 2 && bus.dm_write;
               both = port == 2 && bus.dm_read && bus.dm_write;
            end
         end
         if (done_if) if_p = 0;
         if (done_dm) dm_p = 0;
         @(negedge clk);
      end
      drop_all();
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_dm_store_wait();
      test_starvation();
      test_both_high();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
